check_node_minsum_accum: RTL and testbench
==========================================

// Module: check_node_minsum_accum
// PURPOSE
//  Serial min-sum check-node accumulator. Takes one sign-magnitude variable-to-check message per
//  handshake and tracks min, second-min, min index, sign parity and per-edge signs. On the row's
//  last edge it emits one registered check-row summary.
//  Sits directly upstream of the combinational min/second-min comparator tree: its summaries are
//  the min/sec_min pairs that tree merges, and it also feeds the check-to-variable message generator.
// PARAMETERS
//  PREC     5   magnitude width in bits; matches comparator prec
//  MAX_DEG  32  maximum check-node degree (edges per row)
//  IDX_W    5   edge-index width, = clog2(MAX_DEG)
// PORTS
//  clk           in   1          single clock, all state on rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  in_valid      in   1          input message valid
//  in_ready      out  1          block can accept a message
//  in_mag        in   PREC       message magnitude, unsigned
//  in_sign       in   1          message sign, 1 = negative
//  in_last       in   1          message is the last edge of the current row
//  out_valid     out  1          row summary valid
//  out_ready     in   1          consumer accepts summary
//  out_min       out  PREC       smallest magnitude in row
//  out_sec_min   out  PREC       second-smallest magnitude in row
//  out_min_idx   out  IDX_W      edge index (0-based) of out_min
//  out_sign_prod out  1          XOR of all signs in row
//  out_signs     out  MAX_DEG    per-edge signs; bit i = edge i; unused bits 0
//  out_deg       out  IDX_W+1    number of edges in row (1..MAX_DEG)
//  out_err       out  1          row truncated at MAX_DEG without in_last
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0; accumulators min=sec=2^PREC-1, cnt=0, parity=0, signs=0.
//    A partial row in progress at reset is discarded, with no summary produced.
//  - Accept: acc = in_valid && in_ready. in_ready = !out_valid || out_ready.
//    There is no combinational in_valid->in_ready path.
//  - Per accepted message at edge index cnt:
//      if in_mag < min           : sec<=min, min<=in_mag, idx<=cnt
//      else if in_mag < sec      : sec<=in_mag
//      parity^=in_sign; signs[cnt]<=in_sign; cnt<=cnt+1
//  - Ties: an equal magnitude never displaces min. The first occurrence keeps the index, and the
//    equal value becomes sec_min, so min==sec_min is legal.
//  - Row end: end = acc && (in_last || cnt==MAX_DEG-1). The update above, including the current
//    message, is written straight into the output registers.
//    out_valid rises the cycle after the last accept, so latency from last accept is 1 cycle.
//    The accumulators are re-initialised (min=sec=max, cnt=0, parity=0, signs=0) on that same edge.
//  - out_err=1 iff the row ended by cnt==MAX_DEG-1 with in_last=0. The next message then starts a new row.
//  - Degree-1 row: out_sec_min = 2^PREC-1 (saturated "infinity"), out_min_idx=0.
//  - Output hold: while out_valid && !out_ready, all out_* stay stable and in_ready=0.
//  - Back-to-back: out_valid && out_ready in the same cycle as a row-end accept loads the new
//    summary, and out_valid stays 1.
//    out_valid && out_ready with no row end: out_valid<=0 next cycle.
//  - Throughput: one message per cycle when the consumer does not stall.
//  - States (implicit): ACC (out_valid=0); ACC+HOLD (out_valid=1, input stalled until out_ready).
//  - All magnitude compares are unsigned PREC-bit. There is no arithmetic on magnitudes.
// TESTING
//  1 reset; row mags {7,3,9,3} signs {0,1,1,0} last on 4th, out_ready=1 -> min=3, sec=3, idx=1,
//    sign_prod=0, signs=4'b0110, deg=4, err=0, out_valid 1 cycle after 4th accept.
//  2 single-edge row mag=12,sign=1,last -> min=12, sec=31, idx=0, sign_prod=1, deg=1.
//  3 out_ready=0 after row A {5,2}; present row B -> in_ready=0, outputs frozen.
//    Release -> A taken, B accumulates, and B is correct {min, sec} from its own data.
//  4 32 messages mags 31..0, no in_last -> err=1, deg=32, min=0, idx=31, sec=1.
//    Next message starts a fresh row.
//  5 back-to-back rows {4,6} last, {1,8} last with out_ready=1 -> out_valid stays high.
//    Summaries (4,6,0) then (1,8,0) with no bubble.
//  6 assert rst_n=0 mid-row after 2 messages -> outputs 0 immediately.
//    After release, row {10,11} last -> min=10, sec=11, deg=2, with no residue from the aborted row.

Source files
------------

// File: rtl/check_node_minsum_accum.sv
// Serial min-sum check-node accumulator.
// Takes one sign-magnitude variable-to-check message per handshake.
// Tracks min, second-min, min index, sign parity and per-edge signs.
// On the row's last edge it emits one registered row summary.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            message handshake
//   in_mag, in_sign, in_last     message magnitude, sign (1 = negative), last edge of row
//   out_valid/out_ready          summary handshake
//   out_min, out_sec_min         smallest / second-smallest magnitude in row
//   out_min_idx                  0-based edge index of out_min
//   out_sign_prod                XOR of all signs in row
//   out_signs                    per-edge signs, bit i = edge i
//   out_deg                      edges in row (1..MAX_DEG)
//   out_err                      row truncated at MAX_DEG without in_last
module check_node_minsum_accum #(
  parameter int unsigned PREC    = 5,
  parameter int unsigned MAX_DEG = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PREC-1:0]    in_mag,
  input  logic               in_sign,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PREC-1:0]    out_min,
  output logic [PREC-1:0]    out_sec_min,
  output logic [IDX_W-1:0]   out_min_idx,
  output logic               out_sign_prod,
  output logic [MAX_DEG-1:0] out_signs,
  output logic [IDX_W:0]     out_deg,
  output logic               out_err
);

  localparam int unsigned     DEG_W    = IDX_W + 1;
  localparam logic [PREC-1:0] MAG_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DEG - 1);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [PREC-1:0]      min_q, min_d;
  logic [PREC-1:0]      sec_q, sec_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     cnt_q;
  logic                 par_q, par_d;
  logic [MAX_DEG-1:0]   signs_q, signs_d;
  logic                 acc;
  logic                 row_end;

  // Summary register doubles as the hold state; input stalls only while it is unconsumed.
  assign out_valid = (state_q == S_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign row_end   = acc && (in_last || (cnt_q == LAST_IDX));

  // Next accumulator values including the current message, plus next handshake state.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    idx_d   = idx_q;
    par_d   = par_q ^ in_sign;
    signs_d = signs_q;

    // Strict compares: an equal magnitude never displaces min, it becomes sec instead.
    if (in_mag < min_q) begin
      sec_d = min_q;
      min_d = in_mag;
      idx_d = cnt_q;
    end else if (in_mag < sec_q) begin
      sec_d = in_mag;
    end
    signs_d[cnt_q] = in_sign;

    case (state_q)
      S_ACC:   if (row_end) state_d = S_HOLD;
      S_HOLD:  if (row_end) state_d = S_HOLD;
               else if (out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ACC;
    else        state_q <= state_d;
  end

  // Accumulators and summary registers; a row end writes the summary and re-arms the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q         <= MAG_MAX;
      sec_q         <= MAG_MAX;
      idx_q         <= '0;
      cnt_q         <= '0;
      par_q         <= 1'b0;
      signs_q       <= '0;
      out_min       <= '0;
      out_sec_min   <= '0;
      out_min_idx   <= '0;
      out_sign_prod <= 1'b0;
      out_signs     <= '0;
      out_deg       <= '0;
      out_err       <= 1'b0;
    end else if (row_end) begin
      out_min       <= min_d;
      out_sec_min   <= sec_d;
      out_min_idx   <= idx_d;
      out_sign_prod <= par_d;
      out_signs     <= signs_d;
      out_deg       <= DEG_W'({1'b0, cnt_q}) + DEG_W'(1);
      out_err       <= !in_last;
      min_q         <= MAG_MAX;
      sec_q         <= MAG_MAX;
      idx_q         <= '0;
      cnt_q         <= '0;
      par_q         <= 1'b0;
      signs_q       <= '0;
    end else if (acc) begin
      min_q   <= min_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_q + IDX_W'(1);
      par_q   <= par_d;
      signs_q <= signs_d;
    end
  end

endmodule

// File: tb/tb_check_node_minsum_accum.sv
// Self-checking bench for check_node_minsum_accum: directed rows, scoreboard of expected summaries.
module tb_check_node_minsum_accum;

  localparam int unsigned PREC    = 5;
  localparam int unsigned MAX_DEG = 32;
  localparam int unsigned IDX_W   = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [PREC-1:0]    in_mag;
  logic               in_sign;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [PREC-1:0]    out_min;
  logic [PREC-1:0]    out_sec_min;
  logic [IDX_W-1:0]   out_min_idx;
  logic               out_sign_prod;
  logic [MAX_DEG-1:0] out_signs;
  logic [IDX_W:0]     out_deg;
  logic               out_err;

  check_node_minsum_accum #(.PREC(PREC), .MAX_DEG(MAX_DEG), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_sign(in_sign), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_sec_min(out_sec_min), .out_min_idx(out_min_idx),
    .out_sign_prod(out_sign_prod), .out_signs(out_signs),
    .out_deg(out_deg), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PREC-1:0]    min;
    logic [PREC-1:0]    sec;
    logic [IDX_W-1:0]   idx;
    logic               sp;
    logic [MAX_DEG-1:0] signs;
    logic [IDX_W:0]     deg;
    logic               err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [PREC-1:0] row_mag  [MAX_DEG];
  logic            row_sign [MAX_DEG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference summary of the first n entries of row_mag/row_sign.
  task automatic push_exp(input int n, input logic err);
    exp_t e;
    e.min = '1; e.sec = '1; e.idx = '0; e.sp = 1'b0; e.signs = '0;
    for (int i = 0; i < n; i++) begin
      if (row_mag[i] < e.min) begin
        e.sec = e.min; e.min = row_mag[i]; e.idx = IDX_W'(i);
      end else if (row_mag[i] < e.sec) begin
        e.sec = row_mag[i];
      end
      e.sp = e.sp ^ row_sign[i];
      e.signs[i] = row_sign[i];
    end
    e.deg = (IDX_W+1)'(n);
    e.err = err;
    sb.push_back(e);
  endtask

  // Drive one message and wait (bounded) for its acceptance; returns at posedge+1.
  task automatic send(input logic [PREC-1:0] m, input logic s, input logic l);
    logic r;
    bit   ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mag = m; in_sign = s; in_last = l;
    for (int k = 0; k < 200; k++) begin
      #1 r = in_ready;
      @(posedge clk);
      if (r) begin ok = 1; break; end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #2 chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Summary monitor: every consumed summary is compared to the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("min",       64'(out_min),       64'(e.min));
        chk("sec_min",   64'(out_sec_min),   64'(e.sec));
        chk("min_idx",   64'(out_min_idx),   64'(e.idx));
        chk("sign_prod", 64'(out_sign_prod), 64'(e.sp));
        chk("signs",     64'(out_signs),     64'(e.signs));
        chk("deg",       64'(out_deg),       64'(e.deg));
        chk("err",       64'(out_err),       64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mag = '0; in_sign = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_min",   64'(out_min),   64'd0);
    chk("rst_out_sec",   64'(out_sec_min), 64'd0);
    chk("rst_out_deg",   64'(out_deg),   64'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: four-edge row with a tie on the minimum.
    row_mag[0] = 7; row_sign[0] = 0;
    row_mag[1] = 3; row_sign[1] = 1;
    row_mag[2] = 9; row_sign[2] = 1;
    row_mag[3] = 3; row_sign[3] = 0;
    push_exp(4, 1'b0);
    send(7, 0, 0); send(3, 1, 0); send(9, 1, 0);
    chk("t1_not_early", 64'(out_valid), 64'd0);
    send(3, 0, 1);
    chk("t1_latency", 64'(out_valid), 64'd1);
    chk("t1_min",     64'(out_min), 64'd3);
    chk("t1_sec",     64'(out_sec_min), 64'd3);
    chk("t1_signs",   64'(out_signs), 64'h6);
    drain();

    // 2: degree-1 row, sec_min saturates.
    row_mag[0] = 12; row_sign[0] = 1;
    push_exp(1, 1'b0);
    send(12, 1, 1);
    chk("t2_sec_inf", 64'(out_sec_min), 64'd31);
    drain();

    // 3: stalled consumer freezes outputs and input; release lets row B accumulate.
    @(negedge clk) out_ready = 1'b0;
    row_mag[0] = 5; row_sign[0] = 0; row_mag[1] = 2; row_sign[1] = 0;
    push_exp(2, 1'b0);
    send(5, 0, 0); send(2, 0, 1);
    row_mag[0] = 9; row_sign[0] = 0; row_mag[1] = 4; row_sign[1] = 1;
    push_exp(2, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_mag = 9; in_sign = 0; in_last = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_in_ready_low", 64'(in_ready),    64'd0);
      chk("t3_hold_valid",   64'(out_valid),   64'd1);
      chk("t3_hold_min",     64'(out_min),     64'd2);
      chk("t3_hold_sec",     64'(out_sec_min), 64'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("t3_in_ready_rel", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    send(4, 1, 1);
    drain();

    // 4: 32 edges without in_last truncate the row; next message opens a fresh row.
    for (int i = 0; i < 32; i++) begin
      row_mag[i] = PREC'(31 - i); row_sign[i] = 1'(i);
    end
    push_exp(32, 1'b1);
    for (int i = 0; i < 32; i++) send(row_mag[i], row_sign[i], 0);
    chk("t4_err", 64'(out_err), 64'd1);
    chk("t4_deg", 64'(out_deg), 64'd32);
    row_mag[0] = 3; row_sign[0] = 0;
    push_exp(1, 1'b0);
    send(3, 0, 1);
    chk("t4_fresh_deg", 64'(out_deg), 64'd1);
    drain();

    // 5: back-to-back rows with consumer always ready.
    row_mag[0] = 4; row_sign[0] = 0; row_mag[1] = 6; row_sign[1] = 0;
    push_exp(2, 1'b0);
    row_mag[0] = 1; row_sign[0] = 0; row_mag[1] = 8; row_sign[1] = 0;
    push_exp(2, 1'b0);
    send(4, 0, 0); send(6, 0, 1); send(1, 0, 0); send(8, 0, 1);
    chk("t5_second_valid", 64'(out_valid), 64'd1);
    chk("t5_second_min",   64'(out_min),   64'd1);
    // Single-edge rows: a row end while the summary is consumed keeps out_valid high.
    row_mag[0] = 20; row_sign[0] = 1; push_exp(1, 1'b0);
    row_mag[0] = 17; row_sign[0] = 0; push_exp(1, 1'b0);
    row_mag[0] = 25; row_sign[0] = 1; push_exp(1, 1'b0);
    send(20, 1, 1);
    send(17, 0, 1);
    chk("t5_b2b_valid1", 64'(out_valid), 64'd1);
    chk("t5_b2b_min1",   64'(out_min),   64'd17);
    send(25, 1, 1);
    chk("t5_b2b_valid2", 64'(out_valid), 64'd1);
    chk("t5_b2b_min2",   64'(out_min),   64'd25);
    drain();

    // 6: reset mid-row discards the partial row.
    send(1, 1, 0); send(2, 1, 0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_min",   64'(out_min),   64'd0);
    chk("t6_rst_signs", 64'(out_signs), 64'd0);
    chk("t6_rst_deg",   64'(out_deg),   64'd0);
    @(negedge clk) rst_n = 1'b1;
    row_mag[0] = 10; row_sign[0] = 0; row_mag[1] = 11; row_sign[1] = 0;
    push_exp(2, 1'b0);
    send(10, 0, 0); send(11, 0, 1);
    chk("t6_min", 64'(out_min), 64'd10);
    chk("t6_deg", 64'(out_deg), 64'd2);
    drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
